pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register that generalises the fixed per-field stage registers between IF/ID/RR/EX/MEM/WB. It carries one WIDTH-bit bundle per transfer under a valid/ready handshake, supports stall by back-pressure and flush by bubble insertion (loading NOP_VAL), and optionally includes a skid entry so that `in_ready` is registered without losing throughput. Each pipeline boundary instantiates one copy, with the stage's fields concatenated into `in_data`.

## Interface
- WIDTH, 16: payload width in bits; must be at least 1.
- NOP_VAL, {WIDTH{1'b0}}: value loaded into storage on reset and flush; appears on `out_data` whenever `out_valid` = 0.
- CNT_W, 8: width of the stall counter; must be at least 1.

- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream holds a valid bundle.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream bundle.
- out_valid  out  1  `out_data` is valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  head bundle; equals NOP_VAL when `out_valid` = 0.
- occupancy  out  2  number of held entries: 0, 1 or 2.
- stall_cnt  out  CNT_W  saturating count of cycles with `out_valid` = 1 and `out_ready` = 0.

## Operation
- Handshake definitions:
  - Input transfer: `in_valid && in_ready` at a rising edge.
  - Output transfer: `out_valid && out_ready` at a rising edge.
- Storage:
  - Main entry (`main_v`, `main_d`) drives `out_valid`/`out_data`.
  - Skid entry (`skid_v`, `skid_d`) exists only with the skid feature (see Configuration).
- Per-edge update when no flush is active (skid build):
  - Main empty, or main empty after an output transfer: main loads the skid entry if it is valid, otherwise the input on an input transfer. Skid is then cleared, unless an input transfer also occurs, in which case skid captures `in_data`.
  - Main full with no output transfer: an input transfer is written to skid.
- Order is strictly FIFO. No bundle is ever duplicated or dropped except by flush.
- Flush, sampled at the edge:
  - Both entries are invalidated and their data set to NOP_VAL.
  - An input transfer in the same cycle counts as accepted and is discarded.
  - An output transfer in the same cycle still counts as consumed by downstream.
  - Flush has priority over every other event.
- `occupancy` = `main_v` + `skid_v`. It is never 2 without the skid feature.
- `stall_cnt` increments by 1 per stalled cycle and holds at all-ones. It is not cleared by flush, only by reset.
- Reset (asserted low, asynchronous, takes effect mid-transfer):
  - `out_valid` = 0, `out_data` = NOP_VAL, `in_ready` = 1, `occupancy` = 0, `stall_cnt` = 0.
  - Deassertion is synchronised externally; the first edge after release operates normally.

## Timing
- Latency is 1 cycle: a bundle accepted at edge N is on `out_data` with `out_valid` = 1 after edge N.
- Throughput is 1 bundle/cycle while `out_ready` = 1.
- Skid build: `in_ready` = !`skid_v`, a pure register output with no combinational path from `out_ready` or `flush`.
- No-skid build: `in_ready` = !`main_v` || `out_ready` (combinational from `out_ready`).
- Recovery after `out_ready` rises with occupancy 2: the head leaves at that edge and the skid entry is on the output the next cycle. `in_ready` rises after the same edge.
- After a flush edge, `out_valid` = 0 for at least one cycle. A new bundle can be accepted in the first cycle after the flush.

## Configuration
- PIPE_STAGE_SKID_EN defined: two entries, registered `in_ready`, full throughput through stalls.
- PIPE_STAGE_SKID_EN undefined: the skid entry and its logic are removed; `in_ready` is combinational as above and `occupancy` ≤ 1.
- Handshake, flush, reset and counter behaviour are identical in both builds.

## Test plan
- Reset with WIDTH=16, NOP_VAL=16'hF000: drive `reset` low mid-stream -> immediately `out_valid`=0, `out_data`=16'hF000, `occupancy`=0, `stall_cnt`=0, `in_ready`=1.
- Streaming: `out_ready`=1, inputs 16'h0001..16'h0008 on consecutive cycles -> outputs in the same order, each 1 cycle later, with no bubbles.
- Stall (skid build): hold `out_ready`=0 while sending 16'hA1, 16'hA2, 16'hA3 -> `occupancy`=2 and `in_ready`=0 after the second transfer, 16'hA3 is held upstream. Release `out_ready` -> A1, A2, A3 delivered in order and `stall_cnt` equals the number of stalled cycles.
- Flush with `occupancy`=2 and `in_valid`=1 in the same cycle -> next cycle `out_valid`=0, `out_data`=NOP_VAL, `occupancy`=0. The input bundle never appears on the output.
- Saturation: CNT_W=4, hold a stall for 20 cycles -> `stall_cnt` reaches 4'hF and stays there. It remains 4'hF after a flush and returns to 0 only on reset.
- No-skid build: same stall sequence -> `occupancy` never exceeds 1, and `in_ready` follows `out_ready` in the same cycle while the main entry is full.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: flow-controlled pipeline stage register.
// Carries one WIDTH-bit bundle per valid/ready transfer, stalls on
// back-pressure, and flushes by loading NOP_VAL into all storage.
// Optional feature macro: PIPE_STAGE_SKID_EN adds a skid entry so that
// in_ready is a pure register output without losing throughput.
module pipe_stage_reg #(
    parameter int unsigned       WIDTH   = 16,
    parameter logic [WIDTH-1:0]  NOP_VAL = '0,
    parameter int unsigned       CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             main_v;
    logic [WIDTH-1:0] main_d;
    logic             in_xfer;
    logic             out_xfer;

    // Handshake qualifiers shared by both builds
    always_comb begin
        in_xfer  = in_valid && in_ready;
        out_xfer = main_v && out_ready;
    end

    // Head entry drives the output; NOP_VAL whenever nothing is valid
    always_comb begin
        out_valid = main_v;
        out_data  = main_v ? main_d : NOP_VAL;
    end

`ifdef PIPE_STAGE_SKID_EN

    logic             skid_v;
    logic [WIDTH-1:0] skid_d;

    // Registered ready: accept whenever the skid slot is free
    always_comb begin
        in_ready  = !skid_v;
        occupancy = {1'b0, main_v} + {1'b0, skid_v};
    end

    // Two-entry FIFO update: main refills from skid first to keep order
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_v <= 1'b0;
            main_d <= NOP_VAL;
            skid_v <= 1'b0;
            skid_d <= NOP_VAL;
        end else if (flush) begin
            main_v <= 1'b0;
            main_d <= NOP_VAL;
            skid_v <= 1'b0;
            skid_d <= NOP_VAL;
        end else if (!main_v || out_xfer) begin
            if (skid_v) begin
                main_v <= 1'b1;
                main_d <= skid_d;
                if (in_xfer) begin
                    skid_v <= 1'b1;
                    skid_d <= in_data;
                end else begin
                    skid_v <= 1'b0;
                    skid_d <= NOP_VAL;
                end
            end else if (in_xfer) begin
                main_v <= 1'b1;
                main_d <= in_data;
            end else begin
                main_v <= 1'b0;
                main_d <= NOP_VAL;
            end
        end else if (in_xfer) begin
            skid_v <= 1'b1;
            skid_d <= in_data;
        end
    end

`else

    // Ready passes straight through from downstream while main is full
    always_comb begin
        in_ready  = !main_v || out_ready;
        occupancy = {1'b0, main_v};
    end

    // Single-entry update: load on input transfer, else drain to NOP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_v <= 1'b0;
            main_d <= NOP_VAL;
        end else if (flush) begin
            main_v <= 1'b0;
            main_d <= NOP_VAL;
        end else if (!main_v || out_xfer) begin
            main_v <= in_xfer;
            main_d <= in_xfer ? in_data : NOP_VAL;
        end
    end

`endif

    // Saturating stall counter; survives flush, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (main_v && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (WIDTH=16,
// NOP_VAL=16'hF000, CNT_W=4). Expectations adapt to PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    localparam logic [15:0] NOP = 16'hF000;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  occupancy;
    logic [3:0]  stall_cnt;

    int unsigned n_cmp;
    int unsigned n_err;

    pipe_stage_reg #(
        .WIDTH   (16),
        .NOP_VAL (16'hF000),
        .CNT_W   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, verify its immediate effect, release
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".out_data"},  {16'd0, out_data},  {16'd0, NOP});
        check({tag, ".occupancy"}, {30'd0, occupancy}, 32'd0);
        check({tag, ".stall_cnt"}, {28'd0, stall_cnt}, 32'd0);
        check({tag, ".in_ready"},  {31'd0, in_ready},  32'd1);
        #1;
        reset = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic [1:0] occ);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".data"},  {16'd0, out_data},  {16'd0, d});
        check({tag, ".occ"},   {30'd0, occupancy}, {30'd0, occ});
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        #1;
        do_reset("por");
        tick();

        // Streaming 1..8 with out_ready=1: each appears one edge later
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int unsigned i = 1; i <= 8; i++) begin
            in_data = 16'(i);
            check("stream.in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk_out("stream", 1'b1, 16'(i), 2'd1);
        end
        in_valid = 1'b0;
        tick();
        chk_out("stream.drain", 1'b0, NOP, 2'd0);

        // Mid-stream reset while stalled with a nonzero counter
        in_valid  = 1'b1;
        in_data   = 16'h00C1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("midrst.pre_cnt", {28'd0, stall_cnt}, 32'd2);
        do_reset("midrst");
        in_valid = 1'b0;
        tick();
        chk_out("midrst.after", 1'b0, NOP, 2'd0);

        // Stall sequence A1, A2, A3 under back-pressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00A1;
        tick();
        chk_out("stall.a1", 1'b1, 16'h00A1, 2'd1);
        check("stall.cnt0", {28'd0, stall_cnt}, 32'd0);
`ifdef PIPE_STAGE_SKID_EN
        check("stall.rdy1", {31'd0, in_ready}, 32'd1);
        in_data = 16'h00A2;
        tick();
        chk_out("stall.full", 1'b1, 16'h00A1, 2'd2);
        check("stall.rdy_full", {31'd0, in_ready}, 32'd0);
        in_data = 16'h00A3;
        tick();
        chk_out("stall.hold", 1'b1, 16'h00A1, 2'd2);
        out_ready = 1'b1;
        #1;
        check("stall.rdy_reg", {31'd0, in_ready}, 32'd0);
        tick();
        chk_out("stall.a2", 1'b1, 16'h00A2, 2'd1);
        check("stall.rdy_back", {31'd0, in_ready}, 32'd1);
        tick();
        chk_out("stall.a3", 1'b1, 16'h00A3, 2'd1);
`else
        in_data = 16'h00A2;
        check("stall.rdy_lo", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        check("stall.rdy_follow", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        #1;
        check("stall.rdy_drop", {31'd0, in_ready}, 32'd0);
        tick();
        chk_out("stall.hold1", 1'b1, 16'h00A1, 2'd1);
        tick();
        chk_out("stall.hold2", 1'b1, 16'h00A1, 2'd1);
        out_ready = 1'b1;
        tick();
        chk_out("stall.a2", 1'b1, 16'h00A2, 2'd1);
        in_data = 16'h00A3;
        tick();
        chk_out("stall.a3", 1'b1, 16'h00A3, 2'd1);
`endif
        in_valid = 1'b0;
        tick();
        chk_out("stall.drain", 1'b0, NOP, 2'd0);
        check("stall.cnt", {28'd0, stall_cnt}, 32'd2);

        // Flush with storage full and a bundle offered in the same cycle
        do_reset("flrst");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00B1;
        tick();
`ifdef PIPE_STAGE_SKID_EN
        in_data = 16'h00B2;
        tick();
        chk_out("flush.pre", 1'b1, 16'h00B1, 2'd2);
`else
        chk_out("flush.pre", 1'b1, 16'h00B1, 2'd1);
`endif
        in_data   = 16'h00B3;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_out("flush.post", 1'b0, NOP, 2'd0);
        tick();
        chk_out("flush.nob3", 1'b0, NOP, 2'd0);
        in_valid = 1'b1;
        in_data  = 16'h00C7;
        tick();
        chk_out("flush.new", 1'b1, 16'h00C7, 2'd1);
        in_valid = 1'b0;
        tick();

        // Counter saturation at 4'hF, survives flush, cleared by reset
        do_reset("satrst");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00D1;
        tick();
        in_valid = 1'b0;
        for (int unsigned i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("sat.cnt%0d", i), {28'd0, stall_cnt}, (i > 15) ? 32'd15 : 32'(i));
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sat.flush", {28'd0, stall_cnt}, 32'd15);
        tick();
        check("sat.hold", {28'd0, stall_cnt}, 32'd15);
        do_reset("sat.reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
